// File: rtl/clock_monitor_pkg.sv
// clock_monitor_pkg: shared state encoding and default window constants for clock_monitor
package clock_monitor_pkg;
  typedef enum logic [2:0] {IDLE, ACQUIRE, MEASURE, LOCKED, LOST} state_t;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_PERIOD_MIN = 90;
  localparam int DEF_PERIOD_MAX = 110;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronises an async strobe and emits a one-cycle pulse on its rising edge
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic pulse
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], sig_in};
      prev  <= sync[STAGES-1];
      pulse <= sync[STAGES-1] & ~prev;
    end
  end
endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: measures the period of a slow async clock, checks it against a window and tracks lock
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PERIOD_MIN  = DEF_PERIOD_MIN,
  parameter int PERIOD_MAX  = DEF_PERIOD_MAX,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic             clk_ok,
  output logic             period_valid,
  output logic [CNT_W-1:0] period_out,
  output logic             err_fast,
  output logic             err_slow
);
  localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] P_MAX  = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] P_SLOW = CNT_W'(PERIOD_MAX + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] G_LOCK = GW'(LOCK_CNT);
  state_t state, nxt;
  logic det, pv_d, ef_d, es_d;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0] good_cnt, good_nxt, good_inc;
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .sig_in(sig_in),
    .pulse (det)
  );
  assign good_inc = good_cnt == G_LOCK ? G_LOCK : good_cnt + 1'b1;
  assign clk_ok   = state == LOCKED;
  always_comb begin
    nxt      = state;
    good_nxt = good_cnt;
    pv_d     = 1'b0;
    ef_d     = 1'b0;
    es_d     = 1'b0;
    if (!en) begin
      nxt      = IDLE;
      good_nxt = '0;
    end else begin
      case (state)
        IDLE:          nxt = ACQUIRE;
        ACQUIRE, LOST: nxt = det ? MEASURE : state;
        default: begin
          if (det) begin
            pv_d     = 1'b1;
            ef_d     = cnt < P_MIN;
            es_d     = cnt > P_MAX;
            good_nxt = (ef_d || es_d) ? '0 : good_inc;
            nxt      = (ef_d || es_d) ? MEASURE : good_nxt == G_LOCK ? LOCKED : state;
          end else if (cnt == P_SLOW) begin
            es_d     = 1'b1;
            good_nxt = '0;
            nxt      = LOST;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      good_cnt     <= '0;
      period_valid <= 1'b0;
      err_fast     <= 1'b0;
      err_slow     <= 1'b0;
      period_out   <= '0;
    end else begin
      state        <= nxt;
      good_cnt     <= good_nxt;
      cnt          <= state == IDLE ? '0 : det ? CNT_W'(1) : cnt == '1 ? cnt : cnt + 1'b1;
      period_valid <= pv_d;
      err_fast     <= ef_d;
      err_slow     <= es_d;
      if (pv_d) period_out <= cnt;
    end
  end
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed self-checking bench for clock_monitor
module tb_clock_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic sig_in = 1'b0;
  logic clk_ok, period_valid, err_fast, err_slow;
  logic [15:0] period_out;
  logic [15:0] last_p = '0;
  logic ok_prev = 1'b0;
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int pv_n = 0;
  int ef_n = 0;
  int es_n = 0;
  int both_n = 0;
  int pv_cyc = 0;
  int es_cyc = 0;
  int first_pv = 0;
  int ok_rise = 0;
  int start = 0;
  clock_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sig_in      (sig_in),
    .clk_ok      (clk_ok),
    .period_valid(period_valid),
    .period_out  (period_out),
    .err_fast    (err_fast),
    .err_slow    (err_slow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
    ncyc++;
    if (period_valid) begin
      pv_n++;
      pv_cyc = ncyc;
      last_p = period_out;
      if (pv_n == 1) first_pv = ncyc;
    end
    if (err_fast) ef_n++;
    if (err_slow) begin
      es_n++;
      es_cyc = ncyc;
    end
    if (err_fast && err_slow) both_n++;
    if (clk_ok && !ok_prev) ok_rise = ncyc;
    ok_prev = clk_ok;
  endtask
  task automatic zero();
    pv_n = 0;
    ef_n = 0;
    es_n = 0;
  endtask
  task automatic edges(input int p, input int n);
    repeat (n) begin
      sig_in = 1'b1;
      repeat (p / 2) tick();
      sig_in = 1'b0;
      repeat (p - p / 2) tick();
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_clk_ok", 32'(clk_ok), 0);
    chk("rst_period_valid", 32'(period_valid), 0);
    chk("rst_period_out", 32'(period_out), 0);
    chk("rst_err_fast", 32'(err_fast), 0);
    chk("rst_err_slow", 32'(err_slow), 0);
    en = 1'b1;
    repeat (5) tick();
    zero();
    start = ncyc;
    edges(100, 6);
    chk("t1_pv_count", pv_n, 5);
    chk("t1_period", 32'(last_p), 100);
    chk("t1_clk_ok", 32'(clk_ok), 1);
    chk("t1_pv_latency", first_pv - start, 104);
    chk("t1_lock_time", ok_rise - first_pv, 300);
    chk("t1_no_err", ef_n + es_n, 0);
    zero();
    repeat (200) tick();
    chk("t2_err_slow_once", es_n, 1);
    chk("t2_slow_gap", es_cyc - pv_cyc, 111);
    chk("t2_clk_ok", 32'(clk_ok), 0);
    chk("t2_no_fast", ef_n, 0);
    zero();
    edges(100, 6);
    chk("t2_relock_pv", pv_n, 5);
    chk("t2_relock", 32'(clk_ok), 1);
    zero();
    edges(90, 1);
    edges(110, 1);
    edges(89, 1);
    chk("t3_window_pv", pv_n, 3);
    chk("t3_period_110", 32'(last_p), 110);
    chk("t3_window_ok", 32'(clk_ok), 1);
    chk("t3_window_no_err", ef_n + es_n, 0);
    edges(111, 1);
    chk("t3_fast89", ef_n, 1);
    chk("t3_period_89", 32'(last_p), 89);
    chk("t3_drop", 32'(clk_ok), 0);
    zero();
    edges(100, 1);
    chk("t3_slow111", es_n, 1);
    chk("t3_period_111", 32'(last_p), 111);
    chk("t3_slow111_pv", pv_n, 1);
    chk("t3_slow111_no_fast", ef_n, 0);
    edges(100, 4);
    chk("t3_relock", 32'(clk_ok), 1);
    zero();
    edges(50, 4);
    chk("t4_fast_n", ef_n, 3);
    chk("t4_pv_n", pv_n, 4);
    chk("t4_period", 32'(last_p), 50);
    chk("t4_clk_ok", 32'(clk_ok), 0);
    edges(100, 5);
    chk("t4_relock", 32'(clk_ok), 1);
    sig_in = 1'b1;
    repeat (50) tick();
    sig_in = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_clk_ok", 32'(clk_ok), 0);
    chk("t5_period_out", 32'(period_out), 0);
    chk("t5_pv", 32'(period_valid), 0);
    chk("t5_errs", 32'(err_fast | err_slow), 0);
    repeat (30) tick();
    zero();
    edges(100, 5);
    chk("t5_relock_pv", pv_n, 4);
    chk("t5_relock", 32'(clk_ok), 1);
    chk("t5_period", 32'(period_out), 100);
    zero();
    sig_in = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    repeat (47) tick();
    sig_in = 1'b0;
    repeat (50) tick();
    chk("t6_no_pv", pv_n, 0);
    chk("t6_clk_ok", 32'(clk_ok), 0);
    chk("t6_hold_period", 32'(period_out), 100);
    chk("t6_no_err", ef_n + es_n, 0);
    en = 1'b1;
    repeat (10) tick();
    zero();
    edges(100, 5);
    chk("t6_relock_pv", pv_n, 4);
    chk("t6_relock", 32'(clk_ok), 1);
    chk("never_both_errs", both_n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
